// File: rtl/phys_reg_free_list.sv
// Multi-port free list of physical register indices for rename, with a committed
// head pointer so a flush returns every speculative allocation in one cycle.
package general_defines;
  localparam int PHYS_REG_LENGTH = 64;
  localparam int ARCH_REG_LENGTH = 32;
  localparam int PHYS_REG_IDX_W  = $clog2(PHYS_REG_LENGTH);
endpackage

module phys_reg_free_list #(
  parameter int PHYS_REGS   = general_defines::PHYS_REG_LENGTH,
  parameter int ARCH_REGS   = general_defines::ARCH_REG_LENGTH,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [ALLOC_PORTS-1:0]                          alloc_req,
  output logic                                            alloc_gnt,
  output logic [ALLOC_PORTS*general_defines::PHYS_REG_IDX_W-1:0] alloc_idx,
  input  logic [FREE_PORTS-1:0]                           free_valid,
  input  logic [FREE_PORTS*general_defines::PHYS_REG_IDX_W-1:0]  free_idx,
  input  logic [$clog2(ALLOC_PORTS+1)-1:0]                commit_alloc_cnt,
  input  logic                                            flush,
  output logic [$clog2(PHYS_REGS-ARCH_REGS+1)-1:0]        free_count,
  output logic                                            empty,
  output logic                                            err
);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int IDX_W    = general_defines::PHYS_REG_IDX_W;
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);
  localparam int A_W      = $clog2(ALLOC_PORTS + 1);
  localparam int F_W      = $clog2(FREE_PORTS + 1);
  localparam int PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CX_W     = CNT_W + 1;

  logic [IDX_W-1:0] mem_q [FL_DEPTH];
  logic [IDX_W-1:0] mem_d [FL_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, cmt_head_q, cmt_head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, out_q, out_d;
  logic             empty_q, empty_d, err_q, err_d;

  logic [A_W-1:0]   n_req, rank;
  logic [PTR_W-1:0] off;
  logic [CNT_W-1:0] grant_cnt, eff_cmt;
  logic             cmt_over, ovf;
  logic [CX_W-1:0]  base;
  logic [F_W-1:0]   n_acc;

  // Requested lanes take consecutive entries from head in lane order; idle lanes show head+k.
  always_comb begin
    n_req     = '0;
    rank      = '0;
    off       = '0;
    alloc_idx = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      n_req = n_req + A_W'(alloc_req[k]);
    end
    alloc_gnt = (n_req != '0) && (CX_W'(count_q) >= CX_W'(n_req)) && !flush;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      off = alloc_req[k] ? PTR_W'(rank) : PTR_W'(k);
      alloc_idx[k*IDX_W +: IDX_W] = mem_q[head_q + off];
      rank = rank + A_W'(alloc_req[k]);
    end
    grant_cnt = alloc_gnt ? CNT_W'(n_req) : '0;
  end

  // Commit retires at most the outstanding allocations; anything beyond is an error.
  always_comb begin
    cmt_over   = CX_W'(commit_alloc_cnt) > CX_W'(out_q);
    eff_cmt    = cmt_over ? out_q : CNT_W'(commit_alloc_cnt);
    cmt_head_d = cmt_head_q + PTR_W'(eff_cmt);
    out_d      = flush ? '0 : (out_q - eff_cmt + grant_cnt);
    head_d     = flush ? cmt_head_d : (head_q + PTR_W'(grant_cnt));
  end

  // Releases append at tail; a lane that would push the count past the depth is dropped.
  always_comb begin
    mem_d = mem_q;
    ovf   = 1'b0;
    n_acc = '0;
    base  = CX_W'(count_q) - CX_W'(grant_cnt) + (flush ? CX_W'(out_q - eff_cmt) : CX_W'(0));
    for (int k = 0; k < FREE_PORTS; k++) begin
      if (free_valid[k]) begin
        if ((base + CX_W'(n_acc)) < CX_W'(FL_DEPTH)) begin
          mem_d[tail_q + PTR_W'(n_acc)] = free_idx[k*IDX_W +: IDX_W];
          n_acc = n_acc + F_W'(1);
        end else begin
          ovf = 1'b1;
        end
      end else begin
        n_acc = n_acc;
      end
    end
    count_d = CNT_W'(base + CX_W'(n_acc));
    tail_d  = tail_q + PTR_W'(n_acc);
    empty_d = (count_d == '0);
    err_d   = err_q | ovf | cmt_over;
  end

  // State registers; reset maps entry i to the first unmapped register ARCH_REGS+i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= IDX_W'(ARCH_REGS + i);
      end
      head_q     <= '0;
      cmt_head_q <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(FL_DEPTH);
      out_q      <= '0;
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      cmt_head_q <= cmt_head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_q      <= out_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
    end
  end

  assign free_count = count_q;
  assign empty      = empty_q;
  assign err        = err_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios plus randomized
// traffic compared against a queue-based model of the free list.
module tb_phys_reg_free_list;
  localparam int IW = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  alloc_req = 2'b00;
  logic        alloc_gnt;
  logic [11:0] alloc_idx;
  logic [1:0]  free_valid = 2'b00;
  logic [11:0] free_idx = 12'd0;
  logic [1:0]  commit_alloc_cnt = 2'd0;
  logic        flush = 1'b0;
  logic [5:0]  free_count;
  logic        empty;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_idx        (alloc_idx),
    .free_valid       (free_valid),
    .free_idx         (free_idx),
    .commit_alloc_cnt (commit_alloc_cnt),
    .flush            (flush),
    .free_count       (free_count),
    .empty            (empty),
    .err              (err)
  );

  function automatic int lane(input int k);
    return int'(alloc_idx[k*IW +: IW]);
  endfunction

  // Inputs change just after a falling edge and settle before the checks.
  task automatic set_in(input logic [1:0] req, input logic [1:0] fv, input int f0,
                        input int f1, input int cmt, input logic fl);
    alloc_req        = req;
    free_valid       = fv;
    free_idx         = {6'(f1), 6'(f0)};
    commit_alloc_cnt = 2'(cmt);
    flush            = fl;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    alloc_req = 2'b00; free_valid = 2'b00; free_idx = 12'd0;
    commit_alloc_cnt = 2'd0; flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd32) begin failures++; $display("FAIL reset_count got=%0d exp=32", free_count); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL reset_empty got=%0b exp=0", empty); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%0b exp=0", alloc_gnt); end
    checks++; if (lane(0) != 32) begin failures++; $display("FAIL reset_lane0 got=%0d exp=32", lane(0)); end
    checks++; if (lane(1) != 33) begin failures++; $display("FAIL reset_lane1 got=%0d exp=33", lane(1)); end
  endtask

  task automatic test_dual_alloc();
    do_reset();
    set_in(2'b11, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL dual_gnt got=%0b exp=1", alloc_gnt); end
    checks++; if (lane(0) != 32 || lane(1) != 33) begin failures++; $display("FAIL dual_idx got=%0d,%0d exp=32,33", lane(0), lane(1)); end
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd30) begin failures++; $display("FAIL dual_count got=%0d exp=30", free_count); end
    checks++; if (lane(0) != 34) begin failures++; $display("FAIL dual_next_lane0 got=%0d exp=34", lane(0)); end
    set_in(2'b10, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (alloc_gnt !== 1'b1 || lane(1) != 34) begin failures++; $display("FAIL lane1_only got gnt=%0b idx=%0d exp gnt=1 idx=34", alloc_gnt, lane(1)); end
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd29) begin failures++; $display("FAIL lane1_only_count got=%0d exp=29", free_count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, 2'b00, 0, 0, 0, 1'b0);
      checks++; if (alloc_gnt !== 1'b1 || lane(0) != 32 + 2*i) begin failures++; $display("FAIL flush_prep_alloc got gnt=%0b idx=%0d exp gnt=1 idx=%0d", alloc_gnt, lane(0), 32 + 2*i); end
      step();
    end
    set_in(2'b00, 2'b00, 0, 0, 2, 1'b0);
    step();
    set_in(2'b11, 2'b00, 0, 0, 0, 1'b1);
    checks++; if (free_count !== 6'd26) begin failures++; $display("FAIL flush_pre_count got=%0d exp=26", free_count); end
    checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL flush_cycle_gnt got=%0b exp=0", alloc_gnt); end
    step();
    set_in(2'b01, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd30) begin failures++; $display("FAIL flush_count got=%0d exp=30", free_count); end
    checks++; if (alloc_gnt !== 1'b1 || lane(0) != 34) begin failures++; $display("FAIL flush_realloc got gnt=%0b idx=%0d exp gnt=1 idx=34", alloc_gnt, lane(0)); end
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd29) begin failures++; $display("FAIL flush_after_count got=%0d exp=29", free_count); end
  endtask

  task automatic test_drain();
    do_reset();
    repeat (16) begin
      set_in(2'b11, 2'b00, 0, 0, 0, 1'b0);
      step();
    end
    set_in(2'b01, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd0 || empty !== 1'b1) begin failures++; $display("FAIL drain_empty got count=%0d empty=%0b exp count=0 empty=1", free_count, empty); end
    checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL drain_gnt got=%0b exp=0", alloc_gnt); end
    set_in(2'b00, 2'b01, 5, 0, 0, 1'b0);
    step();
    set_in(2'b11, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd1 || empty !== 1'b0) begin failures++; $display("FAIL drain_release got count=%0d empty=%0b exp count=1 empty=0", free_count, empty); end
    checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL drain_two_of_one got=%0b exp=0", alloc_gnt); end
    set_in(2'b01, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (alloc_gnt !== 1'b1 || lane(0) != 5) begin failures++; $display("FAIL drain_regrant got gnt=%0b idx=%0d exp gnt=1 idx=5", alloc_gnt, lane(0)); end
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd0 || empty !== 1'b1) begin failures++; $display("FAIL drain_final got count=%0d empty=%0b exp count=0 empty=1", free_count, empty); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (11) begin
      set_in(2'b11, 2'b00, 0, 0, 0, 1'b0);
      step();
    end
    set_in(2'b11, 2'b11, 7, 9, 1, 1'b0);
    checks++; if (free_count !== 6'd10) begin failures++; $display("FAIL simul_pre_count got=%0d exp=10", free_count); end
    checks++; if (alloc_gnt !== 1'b1 || lane(0) != 54 || lane(1) != 55) begin failures++; $display("FAIL simul_grant got gnt=%0b idx=%0d,%0d exp gnt=1 idx=54,55", alloc_gnt, lane(0), lane(1)); end
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (free_count !== 6'd10) begin failures++; $display("FAIL simul_count got=%0d exp=10", free_count); end
    // 23 allocations remain outstanding: retiring exactly 23 is legal, one more is not.
    repeat (11) begin
      set_in(2'b00, 2'b00, 0, 0, 2, 1'b0);
      step();
    end
    set_in(2'b00, 2'b00, 0, 0, 1, 1'b0);
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (err !== 1'b0 || free_count !== 6'd10) begin failures++; $display("FAIL simul_outstanding got err=%0b count=%0d exp err=0 count=10", err, free_count); end
    set_in(2'b00, 2'b00, 0, 0, 1, 1'b0);
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL simul_overcommit got=%0b exp=1", err); end
  endtask

  task automatic test_errors();
    do_reset();
    set_in(2'b00, 2'b01, 3, 0, 0, 1'b0);
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (err !== 1'b1 || free_count !== 6'd32) begin failures++; $display("FAIL err_overflow got err=%0b count=%0d exp err=1 count=32", err, free_count); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky_ovf got=%0b exp=1", err); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || free_count !== 6'd32) begin failures++; $display("FAIL async_reset got err=%0b count=%0d exp err=0 count=32", err, free_count); end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(2'b00, 2'b00, 0, 0, 1, 1'b0);
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checks++; if (err !== 1'b1 || free_count !== 6'd32) begin failures++; $display("FAIL err_commit got err=%0b count=%0d exp err=1 count=32", err, free_count); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky_cmt got=%0b exp=1", err); end
  endtask

  // Model: ordered queue of free indices, queue of speculative grants, and a
  // credit of committed allocations whose old mapping may legally be released.
  task automatic test_random();
    int fq[$];
    int sq[$];
    int inuse[$];
    int credit;
    int cred;
    int f[2];
    int n, r, cmt, j, lim;
    logic [1:0] req, fv;
    logic fl, exp_gnt;
    do_reset();
    credit = 0;
    for (int i = 0; i < 32; i++) begin
      fq.push_back(32 + i);
      inuse.push_back(i);
    end
    for (int c = 0; c < 800; c++) begin
      req = 2'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 15) == 0);
      lim = (sq.size() < 2) ? sq.size() : 2;
      cmt = $urandom_range(0, lim);
      fv  = 2'b00;
      f[0] = 0; f[1] = 0;
      cred = credit;
      for (int k = 0; k < 2; k++) begin
        if (cred > 0 && $urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, inuse.size() - 1);
          f[k] = inuse[j];
          inuse.delete(j);
          fv[k] = 1'b1;
          cred--;
        end
      end
      n = int'(req[0]) + int'(req[1]);
      exp_gnt = (n != 0) && (fq.size() >= n) && !fl;
      set_in(req, fv, f[0], f[1], cmt, fl);
      checks++; if (alloc_gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%0b exp=%0b", c, alloc_gnt, exp_gnt); end
      if (exp_gnt) begin
        r = 0;
        for (int k = 0; k < 2; k++) begin
          if (req[k]) begin
            checks++; if (lane(k) != fq[r]) begin failures++; $display("FAIL rand_idx cyc=%0d lane=%0d got=%0d exp=%0d", c, k, lane(k), fq[r]); end
            r++;
          end
        end
      end
      step();
      if (exp_gnt) repeat (n) sq.push_back(fq.pop_front());
      repeat (cmt) inuse.push_back(sq.pop_front());
      credit = cred + cmt;
      if (fl) begin
        fq = {sq, fq};
        sq.delete();
      end
      for (int k = 0; k < 2; k++) if (fv[k]) fq.push_back(f[k]);
      checks++; if (int'(free_count) != fq.size() || empty !== (fq.size() == 0) || err !== 1'b0) begin
        failures++;
        $display("FAIL rand_state cyc=%0d got count=%0d empty=%0b err=%0b exp count=%0d empty=%0b err=0",
                 c, free_count, empty, err, fq.size(), (fq.size() == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_dual_alloc();
    test_flush();
    test_drain();
    test_simultaneous();
    test_errors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
